dma_st_sink_unpacker: RTL and testbench
=======================================

// Module: dma_st_sink_unpacker
// PURPOSE
//  Avalon-ST sink for the DMA streaming source (32-bit, sop/eop/empty, ready latency 0).
//  Buffers beats in a word FIFO, checks packet framing and unpacks each word into a
//  byte stream, first symbol = data[31:24]. Downstream byte consumers sit in pll_outclk
//  fabric logic. Saturating packet and error counters go to software.
// PARAMETERS
//  FIFO_DEPTH  16  word FIFO entries; power of 2, >=2; entry = {sop,eop,empty[1:0],data[31:0]}
//  CNT_W       16  width of pkt_count / err_count
// PORTS
//  clk_clk            in   1   single clock; all logic is rising-edge
//  rst_reset_n        in   1   asynchronous, active-low reset
//  asi_data           in   32  sink data, symbol 0 in [31:24]
//  asi_valid          in   1   sink beat valid
//  asi_ready          out  1   sink ready (ready latency 0)
//  asi_startofpacket  in   1   first beat of packet
//  asi_endofpacket    in   1   last beat of packet
//  asi_empty          in   2   unused bytes in eop beat (from the LSB end)
//  byte_data          out  8   unpacked byte
//  byte_valid         out  1   byte_data valid
//  byte_ready         in   1   downstream accepts byte
//  byte_sop           out  1   first byte of packet
//  byte_eop           out  1   last byte of packet
//  stat_clear         in   1   sync pulse, clears pkt_count and err_count
//  pkt_count          out  CNT_W  packets delivered downstream, saturating
//  err_count          out  CNT_W  framing errors, saturating
// BEHAVIOUR
//  Reset: asi_ready=0, byte_valid/sop/eop=0, byte_data=0, counters=0, FIFO empty, FSMs idle.
//   asi_ready=1 from the first edge after reset release. Mid-operation reset discards all.
//  Input: beat accepted when asi_valid&&asi_ready. asi_ready = !fifo_full, taken from the
//   registered count; no lookahead, so no push while full even if a pop occurs that cycle.
//  Framing FSM (input side) IN_IDLE / IN_PKT:
//   IN_IDLE + sop: write the beat. Go IN_PKT, unless eop is also set (single-beat packet).
//   IN_IDLE + !sop: accept and drop the beat (orphan). err_count+1.
//   IN_PKT + sop: err_count+1. Write the beat as a new packet start and stay IN_PKT.
//    The truncated packet carries no eop downstream.
//   IN_PKT + eop: write the beat, go IN_IDLE.
//   asi_empty is used only on eop beats. It is forced to 0 on other beats, with no error.
//  Unpacker FSM (output side) U_EMPTY / U_SHIFT:
//   U_EMPTY: if the FIFO is non-empty, pop into the word register, set idx=0, go U_SHIFT.
//    A word written at edge E is popped at E+1; byte_valid is high after E+1.
//   U_SHIFT: byte_data = word byte idx, counted MSB first.
//    nbytes = eop ? 4-empty : 4.
//    byte_sop = word.sop && idx==0.
//    byte_eop = word.eop && idx==nbytes-1.
//   On byte_valid&&byte_ready: if idx<nbytes-1 then idx+1.
//    Otherwise the last byte is done: if the FIFO is non-empty, pop the next word in
//    the same edge (no bubble); else go U_EMPTY.
//   Outputs hold stable while byte_valid && !byte_ready.
//   Sustained throughput is 1 byte/cycle.
//  Counters: pkt_count+1 when a byte with byte_eop is accepted.
//   Counters saturate at all-ones. stat_clear wins over a coincident increment.
//  Capacity: FIFO_DEPTH words plus 1 word in the unpacker.
// TESTING
//  1. 3-beat packet 0x01020304(sop), 0x05060708, 0x090A0B00(eop, empty=1), byte_ready=1
//     -> bytes 01..0B (11 bytes), sop on 01, eop on 0B, pkt_count=1, err_count=0.
//  2. Single beat 0xAABBCCDD with sop+eop, empty=3 -> one byte 0xAA with byte_sop=byte_eop=1.
//  3. byte_ready=0, continuous valid input -> 17 beats accepted, then asi_ready=0.
//     Release byte_ready -> all 68 bytes in order, none lost or duplicated.
//  4. Beat without sop while idle, then sop in mid-packet -> err_count=2.
//     Orphan yields no bytes; the second packet's first byte has byte_sop=1.
//  5. 4 back-to-back 8-beat packets, byte_ready=1 -> byte_valid is continuous for 128 cycles
//     after the first byte; pkt_count=4.
//  6. rst_reset_n low mid-packet -> byte_valid/asi_ready drop immediately, counters 0.
//     After release, a fresh packet is delivered correctly. stat_clear coincident with
//     an eop accept leaves pkt_count=0.

Source files
------------

// File: rtl/dma_st_sink_unpacker.sv
// Avalon-ST 32-bit sink with packet framing checks, a word FIFO and a
// word-to-byte unpacker (symbol 0 = data[31:24]). Saturating packet and
// framing-error counters are exported for software.
module dma_st_sink_unpacker #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk_clk,
    input  logic             rst_reset_n,
    input  logic [31:0]      asi_data,
    input  logic             asi_valid,
    output logic             asi_ready,
    input  logic             asi_startofpacket,
    input  logic             asi_endofpacket,
    input  logic [1:0]       asi_empty,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             byte_sop,
    output logic             byte_eop,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IN_IDLE, IN_PKT} in_state_t;
    typedef enum logic {U_EMPTY, U_SHIFT} u_state_t;

    // FIFO entry layout: {sop, eop, empty[1:0], data[31:0]}
    logic [35:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          run_q;

    in_state_t     in_state_q, in_state_d;
    u_state_t      u_state_q, u_state_d;
    logic [35:0]   word_q, word_d;
    logic [1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] pkt_q, err_q;

    logic        accept, push, pop, err_inc, fifo_nempty, fire, last_byte;
    logic [35:0] wr_entry;
    logic [1:0]  last_idx;

    // asi_ready comes only from registered state; no push-while-full lookahead
    assign asi_ready   = run_q && (cnt_q != FULL_CNT);
    assign accept      = asi_valid && asi_ready;
    assign fifo_nempty = (cnt_q != '0);
    assign wr_entry    = {asi_startofpacket, asi_endofpacket,
                          asi_endofpacket ? asi_empty : 2'b00, asi_data};

    // Input framing: decide whether an accepted beat is stored or dropped
    always_comb begin
        in_state_d = in_state_q;
        push       = 1'b0;
        err_inc    = 1'b0;
        if (accept) begin
            case (in_state_q)
                IN_IDLE: begin
                    if (asi_startofpacket) begin
                        push       = 1'b1;
                        in_state_d = asi_endofpacket ? IN_IDLE : IN_PKT;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                default: begin
                    // A sop here truncates the open packet; the new beat starts a fresh one
                    push    = 1'b1;
                    err_inc = asi_startofpacket;
                    if (asi_endofpacket) begin
                        in_state_d = IN_IDLE;
                    end
                end
            endcase
        end
    end

    assign last_idx    = word_q[34] ? (2'd3 - word_q[33:32]) : 2'd3;
    assign byte_valid  = (u_state_q == U_SHIFT);
    assign fire        = byte_valid && byte_ready;
    assign last_byte   = (idx_q == last_idx);
    assign byte_sop    = byte_valid && word_q[35] && (idx_q == 2'd0);
    assign byte_eop    = byte_valid && word_q[34] && last_byte;

    // Select the current byte, most significant first
    always_comb begin
        case (idx_q)
            2'd0:    byte_data = word_q[31:24];
            2'd1:    byte_data = word_q[23:16];
            2'd2:    byte_data = word_q[15:8];
            default: byte_data = word_q[7:0];
        endcase
    end

    // Unpacker: load a word, step through its bytes, reload without a bubble
    always_comb begin
        u_state_d = u_state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        pop       = 1'b0;
        case (u_state_q)
            U_EMPTY: begin
                if (fifo_nempty) begin
                    pop       = 1'b1;
                    word_d    = mem_q[rd_ptr_q];
                    idx_d     = 2'd0;
                    u_state_d = U_SHIFT;
                end
            end
            default: begin
                if (fire) begin
                    if (!last_byte) begin
                        idx_d = idx_q + 2'd1;
                    end else if (fifo_nempty) begin
                        pop    = 1'b1;
                        word_d = mem_q[rd_ptr_q];
                        idx_d  = 2'd0;
                    end else begin
                        u_state_d = U_EMPTY;
                    end
                end
            end
        endcase
    end

    // FIFO occupancy follows push/pop of the same cycle
    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage; contents need no reset because pointers define validity
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Control state, pointers, unpacker word register
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            run_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            in_state_q <= IN_IDLE;
            u_state_q  <= U_EMPTY;
            word_q     <= '0;
            idx_q      <= 2'd0;
        end else begin
            run_q      <= 1'b1;
            cnt_q      <= cnt_d;
            in_state_q <= in_state_d;
            u_state_q  <= u_state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Saturating statistics; a clear beats a coincident increment
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            pkt_q <= '0;
            err_q <= '0;
        end else if (stat_clear) begin
            pkt_q <= '0;
            err_q <= '0;
        end else begin
            if (fire && byte_eop && (pkt_q != CNT_MAX)) begin
                pkt_q <= pkt_q + 1'b1;
            end
            if (err_inc && (err_q != CNT_MAX)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign pkt_count = pkt_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_dma_st_sink_unpacker.sv
// Directed bench for dma_st_sink_unpacker: framing, unpacking, backpressure,
// capacity, throughput, counters and mid-operation reset.
module tb_dma_st_sink_unpacker;

    logic        clk_clk = 1'b0;
    logic        rst_reset_n;
    logic [31:0] asi_data;
    logic        asi_valid;
    logic        asi_ready;
    logic        asi_startofpacket;
    logic        asi_endofpacket;
    logic [1:0]  asi_empty;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_sop;
    logic        byte_eop;
    logic        stat_clear;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [9:0] byte_q[$];
    int         cyc_q[$];

    dma_st_sink_unpacker #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
        .clk_clk(clk_clk), .rst_reset_n(rst_reset_n),
        .asi_data(asi_data), .asi_valid(asi_valid), .asi_ready(asi_ready),
        .asi_startofpacket(asi_startofpacket), .asi_endofpacket(asi_endofpacket),
        .asi_empty(asi_empty),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_sop(byte_sop), .byte_eop(byte_eop),
        .stat_clear(stat_clear), .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clk_clk = ~clk_clk;

    // Byte monitor: record every accepted byte {sop,eop,data} and its cycle
    always @(negedge clk_clk) begin
        cyc = cyc + 1;
        if (rst_reset_n && byte_valid && byte_ready) begin
            byte_q.push_back({byte_sop, byte_eop, byte_data});
            cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
        int n;
        asi_data = d; asi_startofpacket = s; asi_endofpacket = e; asi_empty = emp;
        asi_valid = 1'b1;
        n = 0;
        @(negedge clk_clk);
        while (!asi_ready && n < 400) begin
            @(negedge clk_clk);
            n++;
        end
        if (n >= 400) begin
            total++; bad++;
            $error("FAIL send_timeout observed=%0d expected=<400", n);
        end
        @(posedge clk_clk); #1;
    endtask

    task automatic idle_in();
        asi_valid = 1'b0; asi_startofpacket = 1'b0; asi_endofpacket = 1'b0;
        asi_empty = 2'b00; asi_data = 32'h0;
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k;
        k = 0;
        while (byte_q.size() < n && k < 3000) begin
            @(negedge clk_clk);
            k++;
        end
        repeat (6) @(negedge clk_clk);
        chk(tag, byte_q.size(), n);
        @(posedge clk_clk); #1;
    endtask

    task automatic chk_byte(input string tag, input int i, input logic s, input logic e, input logic [7:0] d);
        logic [9:0] got;
        got = (i < byte_q.size()) ? byte_q[i] : 10'h3FF;
        chk($sformatf("%s[%0d]", tag, i), {22'h0, got}, {22'h0, s, e, d});
    endtask

    task automatic clear_stats();
        stat_clear = 1'b1;
        @(posedge clk_clk); #1;
        stat_clear = 1'b0;
    endtask

    initial begin
        int gaps;
        logic [7:0] v;
        rst_reset_n = 1'b0; byte_ready = 1'b0; stat_clear = 1'b0;
        idle_in();

        // Reset state
        repeat (2) @(posedge clk_clk); #1;
        chk("rst_asi_ready", asi_ready, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_byte_sop_eop", {byte_sop, byte_eop}, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_err", err_count, 0);
        rst_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        chk("ready_after_release", asi_ready, 1);

        // T1: 3-beat packet, empty=1 on eop
        byte_ready = 1'b1;
        send(32'h01020304, 1, 0, 2'd0);
        send(32'h05060708, 0, 0, 2'd0);
        send(32'h090A0B00, 0, 1, 2'd1);
        idle_in();
        wait_bytes("t1_nbytes", 11);
        for (int i = 0; i < 11; i++) chk_byte("t1_byte", i, i == 0, i == 10, 8'(i + 1));
        chk("t1_pkt", pkt_count, 1);
        chk("t1_err", err_count, 0);

        // T2: single beat sop+eop, empty=3
        byte_q.delete(); cyc_q.delete();
        send(32'hAABBCCDD, 1, 1, 2'd3);
        idle_in();
        wait_bytes("t2_nbytes", 1);
        chk_byte("t2_byte", 0, 1, 1, 8'hAA);
        chk("t2_pkt", pkt_count, 2);

        // T3: capacity 17 words under backpressure, then drain 68 bytes
        byte_q.delete(); cyc_q.delete();
        byte_ready = 1'b0;
        for (int b = 0; b < 17; b++)
            send({8'(4*b), 8'(4*b+1), 8'(4*b+2), 8'(4*b+3)}, b == 0, b == 16, 2'd0);
        send_extra: begin
            asi_data = 32'hDEADBEEF; asi_startofpacket = 1'b1; asi_valid = 1'b1;
            repeat (3) begin
                @(negedge clk_clk);
                chk("t3_full_ready", asi_ready, 0);
            end
            @(posedge clk_clk); #1;
            idle_in();
        end
        chk("t3_no_bytes_yet", byte_q.size(), 0);
        byte_ready = 1'b1;
        wait_bytes("t3_nbytes", 68);
        for (int i = 0; i < 68; i++) chk_byte("t3_byte", i, i == 0, i == 67, 8'(i));
        chk("t3_pkt", pkt_count, 3);

        // T4: orphan beat and sop inside an open packet
        clear_stats();
        chk("t4_clr_pkt", pkt_count, 0);
        chk("t4_clr_err", err_count, 0);
        byte_q.delete(); cyc_q.delete();
        send(32'h11111111, 0, 0, 2'd0);
        send(32'h21222324, 1, 0, 2'd0);
        send(32'h31323334, 1, 0, 2'd0);
        send(32'h41424344, 0, 1, 2'd0);
        idle_in();
        wait_bytes("t4_nbytes", 12);
        chk_byte("t4_b", 0, 1, 0, 8'h21);
        chk_byte("t4_b", 3, 0, 0, 8'h24);
        chk_byte("t4_b", 4, 1, 0, 8'h31);
        chk_byte("t4_b", 7, 0, 0, 8'h34);
        chk_byte("t4_b", 8, 0, 0, 8'h41);
        chk_byte("t4_b", 11, 0, 1, 8'h44);
        chk("t4_err", err_count, 2);
        chk("t4_pkt", pkt_count, 1);

        // T5: 4 back-to-back 8-beat packets, continuous output
        clear_stats();
        byte_q.delete(); cyc_q.delete();
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 8; b++) begin
                v = 8'(p*32 + b*4);
                send({v, v + 8'd1, v + 8'd2, v + 8'd3}, b == 0, b == 7, 2'd0);
            end
        idle_in();
        wait_bytes("t5_nbytes", 128);
        for (int k = 0; k < 128; k++) chk_byte("t5_byte", k, (k % 32) == 0, (k % 32) == 31, 8'(k));
        gaps = 0;
        for (int k = 1; k < 128 && k < cyc_q.size(); k++)
            if (cyc_q[k] != cyc_q[k-1] + 1) gaps++;
        chk("t5_gaps", gaps, 0);
        chk("t5_pkt", pkt_count, 4);

        // T6: reset mid-packet, fresh packet, clear vs eop accept
        byte_q.delete(); cyc_q.delete();
        byte_ready = 1'b0;
        send(32'hC1C2C3C4, 1, 0, 2'd0);
        send(32'hD1D2D3D4, 0, 0, 2'd0);
        idle_in();
        repeat (2) @(posedge clk_clk); #1;
        chk("t6_pre_valid", byte_valid, 1);
        rst_reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", byte_valid, 0);
        chk("t6_rst_ready", asi_ready, 0);
        chk("t6_rst_pkt", pkt_count, 0);
        chk("t6_rst_err", err_count, 0);
        chk("t6_rst_data", byte_data, 0);
        @(posedge clk_clk); #1;
        rst_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        byte_q.delete(); cyc_q.delete();
        byte_ready = 1'b1;
        send(32'hE1E2E3E4, 1, 0, 2'd0);
        send(32'hF1F2F300, 0, 1, 2'd1);
        idle_in();
        wait_bytes("t6_nbytes", 7);
        chk_byte("t6_b", 0, 1, 0, 8'hE1);
        chk_byte("t6_b", 3, 0, 0, 8'hE4);
        chk_byte("t6_b", 4, 0, 0, 8'hF1);
        chk_byte("t6_b", 6, 0, 1, 8'hF3);
        chk("t6_pkt", pkt_count, 1);

        byte_ready = 1'b0;
        send(32'h5A000000, 1, 1, 2'd3);
        idle_in();
        repeat (3) @(posedge clk_clk); #1;
        chk("t6_hold_valid_eop", {byte_valid, byte_eop}, 2'b11);
        byte_ready = 1'b1; stat_clear = 1'b1;
        @(posedge clk_clk); #1;
        byte_ready = 1'b0; stat_clear = 1'b0;
        chk("t6_clear_wins", pkt_count, 0);
        chk("t6_drained", byte_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
